ay_mix_decim: RTL



---
 rtl/ay_mix_pkg.sv | 19 +
 rtl/ay_vol_lut.sv | 9 +
 rtl/ay_mix_decim.sv | 102 ++++++++++
 3 files changed

// File: rtl/ay_mix_pkg.sv
// ay_mix_pkg: shared widths, the AY logarithmic volume curve and a clog2 helper
package ay_mix_pkg;
    localparam int LVL_W = 4;
    localparam int VOL_W = 12;
    localparam int SUM_W = 15;
    localparam int NCH   = 6;

    localparam logic [VOL_W-1:0] VOL_LUT [16] = '{
        12'd0,   12'd32,  12'd45,   12'd64,   12'd91,   12'd128,  12'd181,  12'd256,
        12'd362, 12'd512, 12'd724,  12'd1024, 12'd1448, 12'd2048, 12'd2896, 12'd4095
    };

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/ay_vol_lut.sv
// ay_vol_lut: maps a 4-bit AY channel level to its 12-bit linear volume
module ay_vol_lut
    import ay_mix_pkg::*;
(
    input  logic [LVL_W-1:0] lvl,
    output logic [VOL_W-1:0] vol
);
    assign vol = VOL_LUT[lvl];
endmodule

// File: rtl/ay_mix_decim.sv
// ay_mix_decim: mixes six AY channels and box-car decimates them to PCM samples
// CHANNEL_MASK_EN adds a per-channel mute input applied at the LUT register stage.
module ay_mix_decim
    import ay_mix_pkg::*;
#(
    parameter int DIV   = 1134,
    parameter int SHIFT = 10,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic [LVL_W-1:0] ay0_a,
    input  logic [LVL_W-1:0] ay0_b,
    input  logic [LVL_W-1:0] ay0_c,
    input  logic [LVL_W-1:0] ay1_a,
    input  logic [LVL_W-1:0] ay1_b,
    input  logic [LVL_W-1:0] ay1_c,
`ifdef CHANNEL_MASK_EN
    input  logic [NCH-1:0]   mute,
`endif
    input  logic             sample_ready,
    output logic [OUT_W-1:0] sample,
    output logic             sample_valid,
    output logic             overrun
);
    localparam int CNT_W = clog2(DIV);
    localparam int ACC_W = SUM_W + CNT_W;

    logic [NCH*LVL_W-1:0] lvl_bus;
    logic [NCH-1:0]       mute_v;
    logic [VOL_W-1:0]     vol [NCH];
    logic [VOL_W-1:0]     vol_d [NCH];
    logic [VOL_W-1:0]     vol_q [NCH];
    logic                 ce1_d, ce1_q, ce2_d, ce2_q;
    logic [SUM_W-1:0]     sum_d, sum_q;
    logic [ACC_W-1:0]     acc_d, acc_q, total;
    logic [CNT_W-1:0]     cnt_d, cnt_q;
    logic [ACC_W+OUT_W-1:0] ext;
    logic [OUT_W-1:0]     sat, sample_d, sample_q;
    logic                 valid_d, valid_q, overrun_d, overrun_q, done;

    assign lvl_bus = {ay1_c, ay1_b, ay1_a, ay0_c, ay0_b, ay0_a};
`ifdef CHANNEL_MASK_EN
    assign mute_v = mute;
`else
    assign mute_v = '0;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        ay_vol_lut u_lut (
            .lvl(lvl_bus[i*LVL_W +: LVL_W]),
            .vol(vol[i])
        );
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) vol_d[i] = mute_v[i] ? '0 : vol[i];
        ce1_d = ce;
        ce2_d = ce1_q;
        sum_d = '0;
        for (int i = 0; i < NCH; i++) sum_d = sum_d + SUM_W'(vol_q[i]);
        done  = ce2_q && (cnt_q == CNT_W'(DIV - 1));
        total = acc_q + ACC_W'(sum_q);
        ext   = {{OUT_W{1'b0}}, total} >> SHIFT;
        sat   = |ext[ACC_W+OUT_W-1:OUT_W] ? '1 : ext[OUT_W-1:0];
        acc_d = done ? '0 : ce2_q ? total : acc_q;
        cnt_d = done ? '0 : ce2_q ? cnt_q + CNT_W'(1) : cnt_q;
        // a full output register only accepts a new sample if it drains this cycle
        sample_d  = (done && (!valid_q || sample_ready)) ? sat : sample_q;
        valid_d   = done || (valid_q && !sample_ready);
        overrun_d = overrun_q || (done && valid_q && !sample_ready);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vol_q     <= '{default: '0};
            ce1_q     <= 1'b0;
            ce2_q     <= 1'b0;
            sum_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            vol_q     <= vol_d;
            ce1_q     <= ce1_d;
            ce2_q     <= ce2_d;
            sum_q     <= sum_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;
endmodule
